// File: rtl/cmos_frame_packer.sv
// Packs OV5640 RGB565 pixels into 32-bit frame-buffer words, one req/ack per frame,
// with per-frame geometry checking, frame skipping and an SDRAM over-length cap.
module cmos_frame_packer #(
  parameter int unsigned H_PIX = 1024,
  parameter int unsigned V_PIX = 768,
  parameter logic [3:0]  SKIP  = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmos_frame_vsync,
  input  logic        cmos_frame_href,
  input  logic        cmos_frame_valid,
  input  logic [15:0] cmos_frame_data,
  output logic        write_req,
  input  logic        write_req_ack,
  output logic        write_en,
  output logic [31:0] write_data,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] frame_cnt
);

  localparam int unsigned FRAME_WORDS = H_PIX * V_PIX;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ARMED, S_ACTIVE, S_DROP} state_t;

  state_t      state_q, state_d;
  logic        vsync_q, vsync_prev_q, href_q, href_prev_q, valid_q;
  logic [15:0] data_q;
  logic        req_q, req_d, wen_q, wen_d, done_q, done_d, err_q, err_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  skip_q, skip_d;
  logic [11:0] h_q, h_d;
  logic [10:0] v_q, v_d;
  logic [23:0] total_q, total_d;
  logic        geom_q, geom_d, ovf_q, ovf_d;
  logic        fs, line_end, start_frame;

  function automatic logic [31:0] expand565(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2], 8'h00};
  endfunction

  assign fs       = vsync_q & ~vsync_prev_q;
  assign line_end = ~href_q & href_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q      <= 1'b0;
      vsync_prev_q <= 1'b0;
      href_q       <= 1'b0;
      href_prev_q  <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
    end else begin
      vsync_q      <= cmos_frame_vsync;
      vsync_prev_q <= vsync_q;
      href_q       <= cmos_frame_href;
      href_prev_q  <= href_q;
      valid_q      <= cmos_frame_valid;
      data_q       <= cmos_frame_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      skip_q  <= '0;
      h_q     <= '0;
      v_q     <= '0;
      total_q <= '0;
      geom_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      skip_q  <= skip_d;
      h_q     <= h_d;
      v_q     <= v_d;
      total_q <= total_d;
      geom_q  <= geom_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    wen_d       = 1'b0;
    wdata_d     = wdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cnt_d       = cnt_q;
    skip_d      = skip_q;
    h_d         = h_q;
    v_d         = v_q;
    total_d     = total_q;
    geom_d      = geom_q;
    ovf_d       = ovf_q;
    start_frame = 1'b0;

    case (state_q)
      S_IDLE: start_frame = fs;
      S_REQ: begin
        if (write_req_ack) begin
          req_d   = 1'b0;
          state_d = S_ARMED;
        end else if (valid_q) begin
          req_d   = 1'b0;
          state_d = S_DROP;
        end
      end
      S_ARMED, S_ACTIVE: begin
        if (fs) begin
          // An fs while still armed is an empty frame: nothing to report, keep waiting.
          if (state_q == S_ACTIVE) begin
            done_d      = 1'b1;
            err_d       = geom_q | ovf_q | (32'(v_q) != V_PIX);
            cnt_d       = cnt_q + 16'd1;
            skip_d      = SKIP;
            start_frame = 1'b1;
          end
          h_d     = '0;
          v_d     = '0;
          total_d = '0;
          geom_d  = 1'b0;
          ovf_d   = 1'b0;
        end else begin
          if (valid_q) begin
            state_d = S_ACTIVE;
            h_d     = h_q + 12'd1;
            if (32'(total_q) < FRAME_WORDS) begin
              wen_d   = 1'b1;
              wdata_d = expand565(data_q);
              total_d = total_q + 24'd1;
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (line_end) begin
            if (32'(h_d) != H_PIX) geom_d = 1'b1;
            h_d = '0;
            v_d = v_q + 11'd1;
          end
        end
      end
      S_DROP: begin
        if (fs) begin
          skip_d      = '0;
          start_frame = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Frame-start handling shared by IDLE, frame close and DROP recovery.
    if (start_frame) begin
      if (skip_d == 4'd0) begin
        state_d = S_REQ;
        req_d   = 1'b1;
      end else begin
        skip_d  = skip_d - 4'd1;
        state_d = S_IDLE;
      end
    end
  end

  assign write_req  = req_q;
  assign write_en   = wen_q;
  assign write_data = wdata_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_cmos_frame_packer.sv
// Randomised self-checking bench for cmos_frame_packer (H_PIX=8, V_PIX=4) against a
// frame-level reference model; a second instance with SKIP=2 covers frame skipping.
module tb_cmos_frame_packer;
  localparam int H = 8;
  localparam int V = 4;
  localparam int WORDS = H * V;

  logic clk = 1'b0, rst_n = 1'b0;
  logic vsync = 1'b0, href = 1'b0, valid = 1'b0, ack = 1'b0, ack2 = 1'b0;
  logic [15:0] data = '0;
  logic req, wen, done, err, req2, wen2, done2, err2;
  logic [31:0] wdata, wdata2;
  logic [15:0] cnt, cnt2;

  int vectors = 0, miscompares = 0, cyc = 0;
  logic [31:0] obs_data[$], exp_data[$], obs2[$];
  int obs_cyc[$], exp_cyc[$];
  int done_n = 0, err_n = 0, done2_n = 0, err2_n = 0;
  bit m_cap, m_bad;
  int m_words, m_lines;
  logic [15:0] line_pix[16];

  cmos_frame_packer #(.H_PIX(H), .V_PIX(V), .SKIP(4'd0)) dut (
    .clk(clk), .rst_n(rst_n), .cmos_frame_vsync(vsync), .cmos_frame_href(href),
    .cmos_frame_valid(valid), .cmos_frame_data(data), .write_req(req),
    .write_req_ack(ack), .write_en(wen), .write_data(wdata), .frame_done(done),
    .frame_err(err), .frame_cnt(cnt));

  cmos_frame_packer #(.H_PIX(H), .V_PIX(V), .SKIP(4'd2)) dut_skip (
    .clk(clk), .rst_n(rst_n), .cmos_frame_vsync(vsync), .cmos_frame_href(href),
    .cmos_frame_valid(valid), .cmos_frame_data(data), .write_req(req2),
    .write_req_ack(ack2), .write_en(wen2), .write_data(wdata2), .frame_done(done2),
    .frame_err(err2), .frame_cnt(cnt2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wen) begin obs_data.push_back(wdata); obs_cyc.push_back(cyc); end
    if (done) begin done_n++; if (err) err_n++; end
    if (wen2) obs2.push_back(wdata2);
    if (done2) begin done2_n++; if (err2) err2_n++; end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Bit replication written as plain arithmetic: x8 = x*2^k + x/2^m.
  function automatic logic [31:0] expand_ref(input logic [15:0] p);
    longint r, g, b;
    r = longint'(p[15:11]); g = longint'(p[10:5]); b = longint'(p[4:0]);
    r = r * 8 + r / 4; g = g * 4 + g / 16; b = b * 8 + b / 4;
    return 32'(r * 16777216 + g * 65536 + b * 256);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_obs();
    obs_data.delete(); obs_cyc.delete(); exp_data.delete(); exp_cyc.delete(); obs2.delete();
    done_n = 0; err_n = 0; done2_n = 0; err2_n = 0;
    m_cap = 0; m_bad = 0; m_words = 0; m_lines = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; vsync = 0; href = 0; valid = 0; ack = 0; ack2 = 0; data = '0;
    repeat (3) tick();
    rst_n = 1;
    tick();
    clear_obs();
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) line_pix[i] = 16'($urandom);
  endtask

  task automatic pulse_fs();
    vsync = 1; tick(); vsync = 0; repeat (3) tick();
  endtask

  task automatic send_line(input int n);
    href = 1;
    for (int i = 0; i < n; i++) begin
      valid = 1; data = line_pix[i];
      if (m_cap) begin
        if (m_words < WORDS) begin
          exp_data.push_back(expand_ref(line_pix[i])); exp_cyc.push_back(cyc);
        end
        m_words++;
      end
      tick();
    end
    valid = 0; href = 0; data = 16'($urandom);
    tick(); tick();
    if (m_cap) begin
      m_lines++;
      if (n != H || m_words > WORDS) m_bad = 1;
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (req) ok = 1; else tick();
    end
  endtask

  task automatic give_ack(input int dly);
    repeat (dly) tick();
    ack = 1; repeat (3) tick(); ack = 0; tick();
  endtask

  task automatic test_reset();
    rst_n = 0; repeat (2) tick();
    vectors++; if (req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_req: got %b want 0", req); end
    vectors++; if (wen !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wen: got %b want 0", wen); end
    vectors++; if (wdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_wdata: got %h want 0", wdata); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err: got %b want 0", err); end
    vectors++; if (cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_cnt: got %0d want 0", cnt); end
    rst_n = 1; repeat (3) tick();
    vectors++; if (req !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_req: got %b want 0", req); end
  endtask

  task automatic test_basic_frame();
    bit ok;
    do_reset();
    for (int i = 0; i < 16; i++) line_pix[i] = 16'hF800;
    pulse_fs(); wait_req(ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_req_timeout: got %b want 1", ok); end
    give_ack(3);
    vectors++; if (req !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_req_drop: got %b want 0", req); end
    m_cap = 1;
    repeat (V) send_line(H);
    pulse_fs();
    vectors++; if (obs_data.size() !== WORDS) begin miscompares++; $display("[TB] FAIL basic_words: got %0d want %0d", obs_data.size(), WORDS); end
    for (int i = 0; i < obs_data.size(); i++) begin
      vectors++; if (obs_data[i] !== 32'hFF000000) begin miscompares++; $display("[TB] FAIL basic_data[%0d]: got %h want ff000000", i, obs_data[i]); end
    end
    vectors++; if (done_n !== 1) begin miscompares++; $display("[TB] FAIL basic_done: got %0d want 1", done_n); end
    vectors++; if (err_n !== 0) begin miscompares++; $display("[TB] FAIL basic_err: got %0d want 0", err_n); end
    vectors++; if (cnt !== 16'd1) begin miscompares++; $display("[TB] FAIL basic_cnt: got %0d want 1", cnt); end
    vectors++; if (req !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_rerequest: got %b want 1", req); end
  endtask

  task automatic test_colour_latency();
    bit ok;
    do_reset();
    pulse_fs(); wait_req(ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL colour_req_timeout: got %b want 1", ok); end
    give_ack(1);
    m_cap = 1;
    for (int l = 0; l < V; l++) begin
      fill_random();
      if (l == 0) begin line_pix[0] = 16'h07E0; line_pix[1] = 16'h8410; end
      send_line(H);
    end
    pulse_fs();
    vectors++; if (obs_data.size() !== exp_data.size()) begin miscompares++; $display("[TB] FAIL colour_words: got %0d want %0d", obs_data.size(), exp_data.size()); end
    vectors++; if (obs_data.size() < 2 || obs_data[0] !== 32'h00FF0000) begin miscompares++; $display("[TB] FAIL colour_green: got %h want 00ff0000", obs_data[0]); end
    vectors++; if (obs_data.size() < 2 || obs_data[1] !== 32'h84828400) begin miscompares++; $display("[TB] FAIL colour_grey: got %h want 84828400", obs_data[1]); end
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      vectors++; if (obs_data[i] !== exp_data[i]) begin miscompares++; $display("[TB] FAIL colour_data[%0d]: got %h want %h", i, obs_data[i], exp_data[i]); end
      vectors++; if (obs_cyc[i] - exp_cyc[i] !== 2) begin miscompares++; $display("[TB] FAIL colour_latency[%0d]: got %0d want 2", i, obs_cyc[i] - exp_cyc[i]); end
    end
    vectors++; if (wdata !== exp_data[exp_data.size() - 1]) begin miscompares++; $display("[TB] FAIL colour_hold: got %h want %h", wdata, exp_data[exp_data.size() - 1]); end
    vectors++; if (done_n !== 1 || err_n !== 0) begin miscompares++; $display("[TB] FAIL colour_done: got %0d/%0d want 1/0", done_n, err_n); end
    vectors++; if (cnt !== 16'd1) begin miscompares++; $display("[TB] FAIL colour_cnt: got %0d want 1", cnt); end
  endtask

  task automatic test_drop();
    bit ok;
    do_reset();
    fill_random();
    pulse_fs(); wait_req(ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL drop_req_timeout: got %b want 1", ok); end
    m_cap = 0;
    send_line(H);
    vectors++; if (req !== 1'b0) begin miscompares++; $display("[TB] FAIL drop_req_abandon: got %b want 0", req); end
    give_ack(1);
    vectors++; if (req !== 1'b0) begin miscompares++; $display("[TB] FAIL drop_late_ack: got %b want 0", req); end
    repeat (V - 1) send_line(H);
    pulse_fs();
    vectors++; if (req !== 1'b1) begin miscompares++; $display("[TB] FAIL drop_rerequest: got %b want 1", req); end
    vectors++; if (obs_data.size() !== 0) begin miscompares++; $display("[TB] FAIL drop_words: got %0d want 0", obs_data.size()); end
    vectors++; if (done_n !== 0) begin miscompares++; $display("[TB] FAIL drop_done: got %0d want 0", done_n); end
    give_ack(2);
    m_cap = 1;
    for (int l = 0; l < V; l++) begin fill_random(); send_line(H); end
    pulse_fs();
    vectors++; if (obs_data.size() !== WORDS) begin miscompares++; $display("[TB] FAIL drop_next_words: got %0d want %0d", obs_data.size(), WORDS); end
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      vectors++; if (obs_data[i] !== exp_data[i]) begin miscompares++; $display("[TB] FAIL drop_next_data[%0d]: got %h want %h", i, obs_data[i], exp_data[i]); end
    end
    vectors++; if (done_n !== 1 || err_n !== 0) begin miscompares++; $display("[TB] FAIL drop_next_done: got %0d/%0d want 1/0", done_n, err_n); end
    vectors++; if (cnt !== 16'd1) begin miscompares++; $display("[TB] FAIL drop_next_cnt: got %0d want 1", cnt); end
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    pulse_fs(); wait_req(ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_req_timeout: got %b want 1", ok); end
    give_ack(1);
    m_cap = 1;
    for (int l = 0; l < V; l++) begin fill_random(); send_line(l == 0 ? H + 1 : H); end
    pulse_fs();
    vectors++; if (obs_data.size() !== WORDS) begin miscompares++; $display("[TB] FAIL ovf_words: got %0d want %0d", obs_data.size(), WORDS); end
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      vectors++; if (obs_data[i] !== exp_data[i]) begin miscompares++; $display("[TB] FAIL ovf_data[%0d]: got %h want %h", i, obs_data[i], exp_data[i]); end
    end
    vectors++; if (done_n !== 1) begin miscompares++; $display("[TB] FAIL ovf_done: got %0d want 1", done_n); end
    vectors++; if (err_n !== int'(m_bad)) begin miscompares++; $display("[TB] FAIL ovf_err: got %0d want %0d", err_n, m_bad); end
    vectors++; if (cnt !== 16'd1) begin miscompares++; $display("[TB] FAIL ovf_cnt: got %0d want 1", cnt); end
  endtask

  task automatic test_skip();
    bit exp_req;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      fill_random();
      pulse_fs();
      exp_req = ((k - 1) % 3 == 0);
      vectors++; if (req2 !== exp_req) begin miscompares++; $display("[TB] FAIL skip_req_fs%0d: got %b want %b", k, req2, exp_req); end
      if (k == 2) begin
        vectors++; if (cnt2 !== 16'd1) begin miscompares++; $display("[TB] FAIL skip_cnt_fs2: got %0d want 1", cnt2); end
      end
      if (req2) begin
        tick(); ack2 = 1; repeat (2) tick(); ack2 = 0; tick();
      end
      m_cap = exp_req; m_words = 0;
      repeat (V) send_line(H);
    end
    vectors++; if (cnt2 !== 16'd2) begin miscompares++; $display("[TB] FAIL skip_cnt: got %0d want 2", cnt2); end
    vectors++; if (done2_n !== 2 || err2_n !== 0) begin miscompares++; $display("[TB] FAIL skip_done: got %0d/%0d want 2/0", done2_n, err2_n); end
    vectors++; if (obs2.size() !== 2 * WORDS) begin miscompares++; $display("[TB] FAIL skip_words: got %0d want %0d", obs2.size(), 2 * WORDS); end
    for (int i = 0; i < obs2.size() && i < exp_data.size(); i++) begin
      vectors++; if (obs2[i] !== exp_data[i]) begin miscompares++; $display("[TB] FAIL skip_data[%0d]: got %h want %h", i, obs2[i], exp_data[i]); end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    pulse_fs(); wait_req(ok); give_ack(1);
    m_cap = 1;
    for (int l = 0; l < V; l++) begin fill_random(); send_line(H); end
    pulse_fs();
    vectors++; if (cnt !== 16'd1) begin miscompares++; $display("[TB] FAIL areset_precnt: got %0d want 1", cnt); end
    give_ack(1);
    href = 1;
    for (int i = 0; i < 4; i++) begin valid = 1; data = 16'($urandom); tick(); end
    #3 rst_n = 0; valid = 0; href = 0;
    #1;
    vectors++; if (req !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_req: got %b want 0", req); end
    vectors++; if (wen !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_wen: got %b want 0", wen); end
    vectors++; if (wdata !== 32'h0) begin miscompares++; $display("[TB] FAIL areset_wdata: got %h want 0", wdata); end
    vectors++; if (done !== 1'b0 || err !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_done: got %b/%b want 0/0", done, err); end
    vectors++; if (cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL areset_cnt: got %0d want 0", cnt); end
    @(posedge clk); #3 rst_n = 1;
    tick();
    clear_obs();
    pulse_fs(); wait_req(ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL areset_rerequest: got %b want 1", ok); end
    give_ack(1);
    m_cap = 1;
    for (int l = 0; l < V; l++) begin fill_random(); send_line(H); end
    pulse_fs();
    vectors++; if (obs_data.size() !== WORDS) begin miscompares++; $display("[TB] FAIL areset_words: got %0d want %0d", obs_data.size(), WORDS); end
    vectors++; if (done_n !== 1 || err_n !== 0) begin miscompares++; $display("[TB] FAIL areset_done_after: got %0d/%0d want 1/0", done_n, err_n); end
    vectors++; if (cnt !== 16'd1) begin miscompares++; $display("[TB] FAIL areset_cnt_after: got %0d want 1", cnt); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_colour_latency();
    test_drop();
    test_overflow();
    test_skip();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
